multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine. The machine drives the shared memory, instruction register, register file, ALU operand muxes and PC enable over several cycles per instruction. It supports R-format, lw, sw, beq and bne. Memory accesses wait on a ready handshake, illegal opcodes halt the core, and retired instructions are counted.

## Interface

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 forces the idle/reset condition immediately
- opcode  in  6  instruction[31:26] from the instruction register; stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access in this cycle
- pc_en  out  1  PC register load enable, including the branch condition
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  write address select: 1 = rd, 0 = rt
- mem_to_reg  out  1  write data select: 1 = memory data register, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct (feeds ALUControl)
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target)
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky flag: unsupported opcode decoded
- retired  out  COUNT_WIDTH  count of completed instructions

## Operation

States and encodings:
- FETCH = 0
- DECODE = 1
- MEM_ADDR = 2
- MEM_READ = 3
- MEM_WB = 4
- MEM_WRITE = 5
- EXECUTE = 6
- ALU_WB = 7
- BRANCH = 8
- HALT = 9

Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_en equal mem_ready.
  - Moves to DECODE when mem_ready=1, otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target).
  - opcode 0 → EXECUTE
  - opcode 35 or 43 → MEM_ADDR
  - opcode 4 or 5 → BRANCH
  - any other opcode → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - opcode 35 → MEM_READ; opcode 43 → MEM_WRITE.
- MEM_READ: mem_read=1, iord=1.
  - Moves to MEM_WB when mem_ready=1, otherwise holds.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- MEM_WRITE: mem_write=1, iord=1.
  - Moves to FETCH when mem_ready=1, otherwise holds.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_en = (opcode==4 & zero) | (opcode==5 & ~zero).
  - Always moves to FETCH.
- HALT: all enables 0; stays in HALT until reset.

Invariants:
- mem_read and mem_write are never both 1.
- reg_write is 1 only in ALU_WB or MEM_WB.

Retired counter:
- Increments by 1 on a completion cycle: ALU_WB, MEM_WB, BRANCH, or MEM_WRITE with mem_ready=1.
- Wraps from 2^COUNT_WIDTH−1 to 0.

Illegal flag:
- Set on the DECODE cycle that takes the HALT branch.
- Cleared only by reset.

## Timing

Reset:
- While reset=0: state=FETCH (0), retired=0, illegal=0, and every enable forced to 0 (mem_read, mem_write, ir_write, pc_en, reg_write).
- Mux selects read 0 during reset.
- Reset asserted mid-instruction abandons it with no register or memory write. The first FETCH read occurs on the first cycle with reset=1.

Latency with mem_ready tied to 1 (clock cycles per instruction):
- beq/bne: 3
- R-format: 4
- sw: 4
- lw: 5

Wait states:
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- During a wait, outputs hold their state values; ir_write and pc_en stay 0.

Output timing:
- All outputs except pc_en and ir_write are Moore and glitch-free relative to state.
- pc_en and ir_write are combinational in mem_ready (FETCH) and in zero/opcode (BRANCH).
- The datapath samples pc_en and ir_write on the next rising edge.
- mem_ready is ignored outside the three access states.

## Test plan

- Reset and R-format: release reset, opcode=0, mem_ready=1.
  - Required: state sequence 0,1,6,7,0.
  - ALU_WB asserts reg_write=1, reg_dst=1; retired=1 after 4 cycles.
- lw with waits: opcode=35, mem_ready low for 2 cycles in MEM_READ.
  - Required: sequence 0,1,2,3,3,3,4,0 (7 cycles).
  - mem_read=1 and iord=1 held throughout MEM_READ; MEM_WB asserts reg_write=1, mem_to_reg=1.
- sw and beq/bne:
  - sw (opcode=43) → MEM_WRITE with mem_write=1, mem_read=0; retired increments on the mem_ready cycle.
  - beq with zero=1 and bne with zero=0 → pc_en=1 in BRANCH.
  - beq with zero=0 and bne with zero=1 → pc_en=0.
- Illegal opcode: opcode=2 in DECODE.
  - Required: state=9, illegal=1, all enables 0 for 20 cycles.
  - A subsequent reset pulse clears illegal and returns to state 0.
- Reset mid-operation and wrap:
  - Assert reset during MEM_WRITE → mem_write drops immediately; retired=0.
  - With COUNT_WIDTH=4, run 16 R-format instructions → retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: Moore FSM driving the shared
// memory, IR, register file, ALU muxes and PC enable; counts retirements.
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic [3:0]             state,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        HALT      = 4'd9
    } state_t;

    state_t cur, nxt;
    logic   done;
    logic   to_halt;
    logic   pc_en_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
    logic   reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur <= FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt          = cur;
        done         = 1'b0;
        to_halt      = 1'b0;
        pc_en_c      = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        pc_source_c  = 2'b00;
        unique case (cur)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_en_c     = mem_ready;
                if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                if (opcode == 6'd0)
                    nxt = EXECUTE;
                else if (opcode == 6'd35 || opcode == 6'd43)
                    nxt = MEM_ADDR;
                else if (opcode == 6'd4 || opcode == 6'd5)
                    nxt = BRANCH;
                else begin
                    nxt     = HALT;
                    to_halt = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                nxt = (opcode == 6'd35) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (mem_ready) nxt = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                done         = 1'b1;
                nxt          = FETCH;
            end
            MEM_WRITE: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                done        = mem_ready;
                if (mem_ready) nxt = FETCH;
            end
            EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                nxt         = ALU_WB;
            end
            ALU_WB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                done        = 1'b1;
                nxt         = FETCH;
            end
            BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b01;
                pc_source_c = 2'b01;
                pc_en_c     = (opcode == 6'd4 && zero) ||
                              (opcode == 6'd5 && !zero);
                done        = 1'b1;
                nxt         = FETCH;
            end
            HALT: nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (done)    retired <= retired + 1'b1;
            if (to_halt) illegal <= 1'b1;
        end
    end

    // Reset is asynchronous, so it masks the decoded outputs directly.
    assign pc_en      = reset & pc_en_c;
    assign iord       = reset & iord_c;
    assign mem_read   = reset & mem_read_c;
    assign mem_write  = reset & mem_write_c;
    assign ir_write   = reset & ir_write_c;
    assign reg_dst    = reset & reg_dst_c;
    assign mem_to_reg = reset & mem_to_reg_c;
    assign reg_write  = reset & reg_write_c;
    assign alu_src_a  = reset & alu_src_a_c;
    assign alu_src_b  = {2{reset}} & alu_src_b_c;
    assign alu_op     = {2{reset}} & alu_op_c;
    assign pc_source  = {2{reset}} & pc_source_c;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected cycle records are queued
// as stimulus is driven and compared against the DUT mid-cycle.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_en, iord, mem_read, mem_write, ir_write;
    logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [3:0]    state;
    logic          illegal;
    logic [CW-1:0] retired;

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]    st;
        logic [14:0]   ctl;
        logic [CW-1:0] ret;
        logic          ill;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    logic [CW-1:0] m_ret = '0;
    logic          m_ill = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Bits: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg
    // reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2]
    function automatic logic [14:0] exp_ctl(input logic [3:0] st,
        input logic rdy, input logic [5:0] op, input logic z);
        logic br;
        br = (op == 6'd4 && z) || (op == 6'd5 && !z);
        case (st)
            4'd0: exp_ctl = {rdy, 1'b0, 1'b1, 1'b0, rdy, 10'b0000_01_00_00};
            4'd1: exp_ctl = 15'b0000_0000_0_11_00_00;
            4'd2: exp_ctl = 15'b0000_0000_1_10_00_00;
            4'd3: exp_ctl = 15'b0110_0000_0_00_00_00;
            4'd4: exp_ctl = 15'b0000_0011_0_00_00_00;
            4'd5: exp_ctl = 15'b0101_0000_0_00_00_00;
            4'd6: exp_ctl = 15'b0000_0000_1_00_10_00;
            4'd7: exp_ctl = 15'b0000_0101_0_00_00_00;
            4'd8: exp_ctl = {br, 14'b000_0000_1_00_01_01};
            default: exp_ctl = '0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic [5:0] op,
                        input logic z, input logic rdy,
                        input logic [3:0] st);
        exp_t e;
        @(negedge clock);
        reset     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        if (!rst) begin
            m_ret = '0;
            m_ill = 1'b0;
        end
        e.st  = rst ? st : 4'd0;
        e.ctl = rst ? exp_ctl(st, rdy, op, z) : 15'd0;
        e.ret = m_ret;
        e.ill = m_ill;
        sb.push_back(e);
        if (rst && (st == 4'd7 || st == 4'd4 || st == 4'd8 ||
                    (st == 4'd5 && rdy)))
            m_ret = m_ret + 1'b1;
        if (rst && st == 4'd1 && !(op == 6'd0 || op == 6'd35 ||
            op == 6'd43 || op == 6'd4 || op == 6'd5))
            m_ill = 1'b1;
    endtask

    task automatic do_r(input int fwait);
        for (int i = 0; i < fwait; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 6);
        step(1, 0, 0, 0, 7);
    endtask

    task automatic do_lw(input int w);
        step(1, 35, 0, 1, 0);
        step(1, 35, 0, 1, 1);
        step(1, 35, 0, 1, 2);
        for (int i = 0; i < w; i++) step(1, 35, 0, 0, 3);
        step(1, 35, 0, 1, 3);
        step(1, 35, 0, 0, 4);
    endtask

    task automatic do_sw_pre();
        step(1, 43, 0, 1, 0);
        step(1, 43, 0, 0, 1);
        step(1, 43, 0, 0, 2);
    endtask

    task automatic do_br(input logic [5:0] op, input logic z);
        step(1, op, z, 1, 0);
        step(1, op, z, 0, 1);
        step(1, op, z, 0, 8);
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("state", 32'(state), 32'(e.st));
                check("ctl", 32'({pc_en, iord, mem_read, mem_write,
                      ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_source}), 32'(e.ctl));
                check("retired", 32'(retired), 32'(e.ret));
                check("illegal", 32'(illegal), 32'(e.ill));
                check("rw_excl", 32'(mem_read & mem_write), 32'd0);
            end
        end
    end

    initial begin
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        do_r(0);
        do_lw(2);
        do_r(2);
        do_sw_pre();
        step(1, 43, 0, 0, 5);
        step(1, 43, 0, 1, 5);
        do_br(4, 1);
        do_br(4, 0);
        do_br(5, 0);
        do_br(5, 1);
        do_lw(0);
        step(1, 2, 0, 1, 0);
        step(1, 2, 0, 1, 1);
        for (int i = 0; i < 20; i++)
            step(1, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9);
        step(0, 0, 0, 1, 0);
        do_r(0);
        do_sw_pre();
        step(1, 43, 0, 0, 5);
        step(0, 43, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) do_r(i % 2);
        step(1, 0, 0, 0, 0);
        @(negedge clock);
        #5;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
